// File: rtl/mmu_drive_fork_if.sv
// Drive/free handshake bundle between an upstream MMU stage and the fork,
// plus the fan-out side towards the parallel consumers.
interface mmu_drive_fork_if #(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 32
);
  logic                 i_drive;
  logic [DATA_W-1:0]    i_data;
  logic [NUM_PORTS-1:0] i_mask;
  logic                 o_free;
  logic [NUM_PORTS-1:0] o_driveNext;
  logic [DATA_W-1:0]    o_dataNext;
  logic [NUM_PORTS-1:0] i_freeNext;
  logic                 o_busy;
  logic                 o_err;
  logic                 i_errClr;

  // Fork side: receives the token and consumer frees, produces drives/free.
  modport slave (
    input  i_drive, i_data, i_mask, i_freeNext, i_errClr,
    output o_free, o_driveNext, o_dataNext, o_busy, o_err
  );

  // Environment side: upstream producer plus the consumers.
  modport master (
    output i_drive, i_data, i_mask, i_freeNext, i_errClr,
    input  o_free, o_driveNext, o_dataNext, o_busy, o_err
  );
endinterface

// File: rtl/mmu_drive_fork.sv
// Fan-out stage: one upstream drive token is forwarded to a masked set of
// consumers; a single free returns upstream once all selected consumers
// have freed, after FREE_DLY extra cycles. All outputs are registered.
module mmu_drive_fork #(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 32,
  parameter int FREE_DLY  = 1
) (
  input  logic              clk,
  input  logic              rstn,
  mmu_drive_fork_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DELAY, RELEASE} state_t;

  // With no delay the release follows the last free directly.
  localparam logic [3:0] DLY_LOAD    = (FREE_DLY == 0) ? 4'd0 : 4'(FREE_DLY - 1);
  localparam state_t     AFTER_FREES = (FREE_DLY == 0) ? RELEASE : DELAY;

  state_t               state_reg, state_next;
  logic [NUM_PORTS-1:0] pending_reg, pending_next;
  logic [3:0]           cnt_reg, cnt_next;
  logic [DATA_W-1:0]    data_reg, data_next;
  logic                 err_reg, err_next;
  logic                 err_set;
  logic [NUM_PORTS-1:0] drive_reg, drive_next;
  logic                 free_reg, free_next;
  logic                 busy_reg, busy_next;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and datapath: token acceptance, pending-mask retirement, delay count.
  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    cnt_next     = cnt_reg;
    data_next    = data_reg;
    case (state_reg)
      IDLE: begin
        if (bus.i_drive) begin
          if (|bus.i_mask) begin
            data_next    = bus.i_data;
            pending_next = bus.i_mask;
            state_next   = ISSUE;
          end else begin
            // Empty selection: nothing to fork, just schedule the release.
            cnt_next   = DLY_LOAD;
            state_next = AFTER_FREES;
          end
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        pending_next = pending_reg & ~bus.i_freeNext;
        if (pending_next == '0) begin
          cnt_next   = DLY_LOAD;
          state_next = AFTER_FREES;
        end
      end
      DELAY: begin
        if (cnt_reg == 4'd0) state_next = RELEASE;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode (registered below) and sticky protocol-error detection.
  always_comb begin
    drive_next = (state_reg == ISSUE) ? pending_reg : '0;
    free_next  = (state_next == RELEASE);
    busy_next  = (state_next != IDLE);
    // Token while busy, free outside WAIT, or free on a non-pending port.
    err_set    = (bus.i_drive && (state_reg != IDLE))
              || ((|bus.i_freeNext) && (state_reg != WAIT))
              || ((state_reg == WAIT) && (|(bus.i_freeNext & ~pending_reg)));
    // A new error outranks a simultaneous clear.
    err_next   = err_set | (err_reg & ~bus.i_errClr);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending_reg <= '0;
      cnt_reg     <= 4'd0;
      data_reg    <= '0;
      err_reg     <= 1'b0;
      drive_reg   <= '0;
      free_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      cnt_reg     <= cnt_next;
      data_reg    <= data_next;
      err_reg     <= err_next;
      drive_reg   <= drive_next;
      free_reg    <= free_next;
      busy_reg    <= busy_next;
    end
  end

  assign bus.o_free      = free_reg;
  assign bus.o_driveNext = drive_reg;
  assign bus.o_dataNext  = data_reg;
  assign bus.o_busy      = busy_reg;
  assign bus.o_err       = err_reg;

endmodule

// File: tb/tb_mmu_drive_fork.sv
// Bench for mmu_drive_fork: two instances (FREE_DLY=1 and FREE_DLY=0) with a
// scoreboard of expected drive/free pulses checked by a negedge monitor.
module tb_mmu_drive_fork;

  typedef struct {
    int          cyc;
    logic [1:0]  mask;
    logic [31:0] data;
  } drv_exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  drv_exp_t q_drv1[$];
  drv_exp_t q_drv0[$];
  int       q_free1[$];
  int       q_free0[$];

  mmu_drive_fork_if #(.NUM_PORTS(2), .DATA_W(32)) bus1 ();
  mmu_drive_fork_if #(.NUM_PORTS(2), .DATA_W(32)) bus0 ();

  mmu_drive_fork #(.NUM_PORTS(2), .DATA_W(32), .FREE_DLY(1)) u_dly1 (
    .clk(clk), .rstn(rstn), .bus(bus1.slave)
  );
  mmu_drive_fork #(.NUM_PORTS(2), .DATA_W(32), .FREE_DLY(0)) u_dly0 (
    .clk(clk), .rstn(rstn), .bus(bus0.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  // Upstream token into the FREE_DLY=1 instance; schedules the expected drive.
  task automatic send1(input logic [1:0] mask, input logic [31:0] data);
    drv_exp_t e;
    if (mask != 2'b00) begin
      e.cyc = cyc + 2; e.mask = mask; e.data = data;
      q_drv1.push_back(e);
    end
    bus1.i_drive = 1'b1; bus1.i_mask = mask; bus1.i_data = data;
    tick();
    bus1.i_drive = 1'b0; bus1.i_mask = 2'b00; bus1.i_data = 32'h0;
  endtask

  task automatic free1(input logic [1:0] mask);
    bus1.i_freeNext = mask;
    tick();
    bus1.i_freeNext = 2'b00;
  endtask

  // Scoreboard: every drive/free pulse must match the head of its queue.
  task automatic monitor();
    drv_exp_t e;
    int       fc;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (bus1.o_driveNext != 2'b00) begin
          checks++;
          if (q_drv1.size() == 0) begin
            errors++;
            $display("FAIL drive1_unexpected got mask %b data %h at cycle %0d, required none", bus1.o_driveNext, bus1.o_dataNext, cyc);
          end else begin
            e = q_drv1.pop_front();
            if (cyc !== e.cyc || bus1.o_driveNext !== e.mask || bus1.o_dataNext !== e.data) begin
              errors++;
              $display("FAIL drive1 got cycle %0d mask %b data %h, required cycle %0d mask %b data %h", cyc, bus1.o_driveNext, bus1.o_dataNext, e.cyc, e.mask, e.data);
            end
          end
        end
        if (bus0.o_driveNext != 2'b00) begin
          checks++;
          if (q_drv0.size() == 0) begin
            errors++;
            $display("FAIL drive0_unexpected got mask %b at cycle %0d, required none", bus0.o_driveNext, cyc);
          end else begin
            e = q_drv0.pop_front();
            if (cyc !== e.cyc || bus0.o_driveNext !== e.mask || bus0.o_dataNext !== e.data) begin
              errors++;
              $display("FAIL drive0 got cycle %0d mask %b data %h, required cycle %0d mask %b data %h", cyc, bus0.o_driveNext, bus0.o_dataNext, e.cyc, e.mask, e.data);
            end
          end
        end
        if (bus1.o_free) begin
          checks++;
          if (q_free1.size() == 0) begin
            errors++;
            $display("FAIL free1_unexpected got pulse at cycle %0d, required none", cyc);
          end else begin
            fc = q_free1.pop_front();
            if (cyc !== fc) begin
              errors++;
              $display("FAIL free1 got cycle %0d, required cycle %0d", cyc, fc);
            end
          end
        end
        if (bus0.o_free) begin
          checks++;
          if (q_free0.size() == 0) begin
            errors++;
            $display("FAIL free0_unexpected got pulse at cycle %0d, required none", cyc);
          end else begin
            fc = q_free0.pop_front();
            if (cyc !== fc) begin
              errors++;
              $display("FAIL free0 got cycle %0d, required cycle %0d", cyc, fc);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({bus1.o_busy, bus1.o_err, bus1.o_free, bus1.o_driveNext} !== 5'b0 || bus1.o_dataNext !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got busy %b err %b free %b drv %b data %h, required all 0", bus1.o_busy, bus1.o_err, bus1.o_free, bus1.o_driveNext, bus1.o_dataNext);
    end
    rstn = 1'b1;
    repeat (2) tick();
    checks++;
    if (bus1.o_busy !== 1'b0 || bus0.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy1 %b busy0 %b, required 0 0", bus1.o_busy, bus0.o_busy);
    end
    $display("txn reset done at cycle %0d", cyc);
  endtask

  task automatic test_basic();
    int n;
    n = cyc;
    send1(2'b11, 32'hDEADBEEF);
    checks++;
    if (bus1.o_busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy_c1 got %b, required 1", bus1.o_busy);
    end
    goto(n + 2);
    checks++;
    if (bus1.o_dataNext !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_data got %h, required deadbeef", bus1.o_dataNext);
    end
    goto(n + 5);
    free1(2'b01);
    goto(n + 8);
    q_free1.push_back(n + 10);
    free1(2'b10);
    goto(n + 10);
    checks++;
    if (bus1.o_busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy_c10 got %b, required 1", bus1.o_busy);
    end
    goto(n + 11);
    checks++;
    if (bus1.o_busy !== 1'b0 || bus1.o_err !== 1'b0) begin
      errors++; $display("FAIL basic_idle got busy %b err %b, required 0 0", bus1.o_busy, bus1.o_err);
    end
    $display("txn basic fork mask 11 started cycle %0d", n);
  endtask

  task automatic test_simultaneous();
    int       n;
    drv_exp_t e;
    n = cyc;
    e.cyc = n + 2; e.mask = 2'b11; e.data = 32'hA5A5_5A5A;
    q_drv0.push_back(e);
    bus0.i_drive = 1'b1; bus0.i_mask = 2'b11; bus0.i_data = 32'hA5A5_5A5A;
    tick();
    bus0.i_drive = 1'b0; bus0.i_mask = 2'b00; bus0.i_data = 32'h0;
    goto(n + 4);
    q_free0.push_back(n + 5);
    bus0.i_freeNext = 2'b11;
    tick();
    bus0.i_freeNext = 2'b00;
    goto(n + 8);
    checks++;
    if (bus0.o_busy !== 1'b0 || bus0.o_err !== 1'b0) begin
      errors++; $display("FAIL simul_idle got busy %b err %b, required 0 0", bus0.o_busy, bus0.o_err);
    end
    $display("txn simultaneous frees FREE_DLY=0 started cycle %0d", n);
  endtask

  task automatic test_partial();
    int n;
    n = cyc;
    send1(2'b10, 32'h0BAD_F00D);
    goto(n + 3);
    free1(2'b01);
    checks++;
    if (bus1.o_err !== 1'b1 || bus1.o_busy !== 1'b1) begin
      errors++; $display("FAIL partial_badfree got err %b busy %b, required 1 1", bus1.o_err, bus1.o_busy);
    end
    goto(n + 5);
    checks++;
    if (bus1.o_busy !== 1'b1) begin
      errors++; $display("FAIL partial_still_busy got %b, required 1", bus1.o_busy);
    end
    q_free1.push_back(n + 7);
    free1(2'b10);
    goto(n + 9);
    checks++;
    if (bus1.o_busy !== 1'b0 || bus1.o_err !== 1'b1) begin
      errors++; $display("FAIL partial_done got busy %b err %b, required 0 1", bus1.o_busy, bus1.o_err);
    end
    bus1.i_errClr = 1'b1;
    tick();
    bus1.i_errClr = 1'b0;
    checks++;
    if (bus1.o_err !== 1'b0) begin
      errors++; $display("FAIL partial_errclr got %b, required 0", bus1.o_err);
    end
    $display("txn partial mask 10 started cycle %0d", n);
  endtask

  task automatic test_zero_mask();
    int n;
    n = cyc;
    q_free1.push_back(n + 2);
    send1(2'b00, 32'h0000_0055);
    goto(n + 4);
    checks++;
    if (bus1.o_busy !== 1'b0 || bus1.o_err !== 1'b0) begin
      errors++; $display("FAIL zero_idle got busy %b err %b, required 0 0", bus1.o_busy, bus1.o_err);
    end
    $display("txn zero mask started cycle %0d", n);
  endtask

  task automatic test_drive_busy();
    int n;
    n = cyc;
    send1(2'b01, 32'hCAFE_F00D);
    goto(n + 3);
    bus1.i_drive = 1'b1; bus1.i_mask = 2'b11; bus1.i_data = 32'h0000_1234;
    tick();
    bus1.i_drive = 1'b0; bus1.i_mask = 2'b00; bus1.i_data = 32'h0;
    checks++;
    if (bus1.o_err !== 1'b1 || bus1.o_dataNext !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL busy_drop got err %b data %h, required 1 cafef00d", bus1.o_err, bus1.o_dataNext);
    end
    goto(n + 6);
    q_free1.push_back(n + 8);
    free1(2'b01);
    goto(n + 10);
    bus1.i_errClr = 1'b1;
    tick();
    bus1.i_errClr = 1'b0;
    checks++;
    if (bus1.o_err !== 1'b0 || bus1.o_busy !== 1'b0) begin
      errors++; $display("FAIL busy_errclr got err %b busy %b, required 0 0", bus1.o_err, bus1.o_busy);
    end
    // Stray free in IDLE together with a clear: the error wins.
    bus1.i_errClr = 1'b1; bus1.i_freeNext = 2'b01;
    tick();
    bus1.i_errClr = 1'b0; bus1.i_freeNext = 2'b00;
    checks++;
    if (bus1.o_err !== 1'b1) begin
      errors++; $display("FAIL err_wins got %b, required 1", bus1.o_err);
    end
    bus1.i_errClr = 1'b1;
    tick();
    bus1.i_errClr = 1'b0;
    checks++;
    if (bus1.o_err !== 1'b0) begin
      errors++; $display("FAIL err_clr2 got %b, required 0", bus1.o_err);
    end
    $display("txn drive while busy started cycle %0d", n);
  endtask

  task automatic test_reset_mid();
    int n;
    n = cyc;
    send1(2'b11, 32'h7777_7777);
    goto(n + 4);
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus1.o_busy, bus1.o_err, bus1.o_free, bus1.o_driveNext} !== 5'b0 || bus1.o_dataNext !== 32'h0) begin
      errors++;
      $display("FAIL reset_async got busy %b err %b free %b drv %b data %h, required all 0", bus1.o_busy, bus1.o_err, bus1.o_free, bus1.o_driveNext, bus1.o_dataNext);
    end
    repeat (2) tick();
    rstn = 1'b1;
    repeat (20) tick();
    n = cyc;
    send1(2'b01, 32'h0000_0099);
    goto(n + 5);
    q_free1.push_back(n + 7);
    free1(2'b01);
    goto(n + 9);
    checks++;
    if (bus1.o_busy !== 1'b0) begin
      errors++; $display("FAIL reset_newtoken got busy %b, required 0", bus1.o_busy);
    end
    $display("txn reset mid-operation, new token cycle %0d", n);
  endtask

  task automatic test_drain();
    repeat (4) tick();
    checks++;
    if (q_drv1.size() != 0 || q_drv0.size() != 0 || q_free1.size() != 0 || q_free0.size() != 0) begin
      errors++;
      $display("FAIL drain got pending drv1 %0d drv0 %0d free1 %0d free0 %0d, required 0", q_drv1.size(), q_drv0.size(), q_free1.size(), q_free0.size());
    end
  endtask

  initial begin
    bus1.i_drive = 1'b0; bus1.i_data = 32'h0; bus1.i_mask = 2'b00;
    bus1.i_freeNext = 2'b00; bus1.i_errClr = 1'b0;
    bus0.i_drive = 1'b0; bus0.i_data = 32'h0; bus0.i_mask = 2'b00;
    bus0.i_freeNext = 2'b00; bus0.i_errClr = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_simultaneous();
    test_partial();
    test_zero_mask();
    test_drive_busy();
    test_reset_mid();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
